// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory-controller port.
// Checks the ROM/IO/RAM map, sequences the access and returns ack/err/rdata to the winner.
module mem_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  last_grant
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  last_grant_q, last_grant_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic                  b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic                  grant_c, sel_b_c, req_we_c, legal_c, read_done_c;
  logic [ADDR_WIDTH-1:0] req_addr_c;
  logic [DATA_WIDTH-1:0] req_wdata_c;

  // Winner selection and address-map check for the request seen this cycle
  always_comb begin
    grant_c     = a_req | b_req;
    sel_b_c     = b_req & (~a_req | ~last_grant_q);
    req_we_c    = sel_b_c ? b_we    : a_we;
    req_addr_c  = sel_b_c ? b_addr  : a_addr;
    req_wdata_c = sel_b_c ? b_wdata : a_wdata;
    legal_c     = ((req_addr_c <= ADDR_WIDTH'(16'h001F)) & ~req_we_c)
                | ((req_addr_c >= ADDR_WIDTH'(16'h0020)) & (req_addr_c <= ADDR_WIDTH'(16'h003F)))
                | ((req_addr_c >= ADDR_WIDTH'(16'h0800)) & (req_addr_c <= ADDR_WIDTH'(16'h0FFF)));
    read_done_c = (cnt_q == CNT_W'(1));
  end

  // State register plus all registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_c) state_d = legal_c ? ISSUE : RESP;
      ISSUE:   if (we_q || read_done_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; ack/err are set on the edge entering RESP
  always_comb begin
    cnt_d        = cnt_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    busy_d       = (state_d != IDLE);
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_c) begin
          last_grant_d = sel_b_c;
          if (legal_c) begin
            mem_addr_d  = req_addr_c;
            mem_wdata_d = req_wdata_c;
            mem_we_d    = req_we_c;
            we_d        = req_we_c;
            cnt_d       = CNT_W'(READ_LATENCY);
          end else begin
            a_ack_d = ~sel_b_c;
            a_err_d = ~sel_b_c;
            b_ack_d = sel_b_c;
            b_err_d = sel_b_c;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          a_ack_d = ~last_grant_q;
          b_ack_d = last_grant_q;
        end else if (read_done_c) begin
          a_ack_d = ~last_grant_q;
          b_ack_d = last_grant_q;
          if (last_grant_q) b_rdata_d = mem_rdata;
          else              a_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign a_ack      = a_ack_q;
  assign a_err      = a_err_q;
  assign a_rdata    = a_rdata_q;
  assign b_ack      = b_ack_q;
  assign b_err      = b_err_q;
  assign b_rdata    = b_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with read latency 1, one with latency 3.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, mem_rdata;
  logic        a_ack, a_err, b_ack, b_err, mem_we, busy, last_grant;
  logic [31:0] a_rdata, b_rdata, mem_wdata;
  logic [15:0] mem_addr;

  logic        a3_req, a3_we, b3_req, b3_we;
  logic [15:0] a3_addr, b3_addr;
  logic [31:0] a3_wdata, b3_wdata, mem3_rdata;
  logic        a3_ack, a3_err, b3_ack, b3_err, mem3_we, busy3, last_grant3;
  logic [31:0] a3_rdata, b3_rdata, mem3_wdata;
  logic [15:0] mem3_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.READ_LATENCY(1), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .last_grant(last_grant)
  );

  mem_bus_arbiter #(.READ_LATENCY(3), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
    .a_ack(a3_ack), .a_err(a3_err), .a_rdata(a3_rdata),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_ack(b3_ack), .b_err(b3_err), .b_rdata(b3_rdata),
    .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_we(mem3_we), .mem_rdata(mem3_rdata),
    .busy(busy3), .last_grant(last_grant3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; drive and sample 1ns after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    mem_rdata = '0;
    a3_req = 0; a3_we = 0; a3_addr = '0; a3_wdata = '0;
    b3_req = 0; b3_we = 0; b3_addr = '0; b3_wdata = '0;
    mem3_rdata = '0;
    step(); step();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
    reset_n = 1'b1;
    step();

    // A read 0x0005, latency 1
    a_req = 1; a_we = 0; a_addr = 16'h0005; mem_rdata = 32'hDEADBEEF;
    step();
    check("rd1_mem_addr", 32'(mem_addr), 32'h0005);
    check("rd1_mem_we", 32'(mem_we), 32'd0);
    check("rd1_early_ack", 32'(a_ack), 32'd0);
    check("rd1_busy", 32'(busy), 32'd1);
    check("rd1_grant", 32'(last_grant), 32'd0);
    a_req = 0;
    step();
    check("rd1_a_ack", 32'(a_ack), 32'd1);
    check("rd1_a_err", 32'(a_err), 32'd0);
    check("rd1_a_rdata", a_rdata, 32'hDEADBEEF);
    check("rd1_b_ack", 32'(b_ack), 32'd0);
    step();
    check("rd1_ack_drop", 32'(a_ack), 32'd0);
    check("rd1_idle", 32'(busy), 32'd0);

    // B write 0x0800
    b_req = 1; b_we = 1; b_addr = 16'h0800; b_wdata = 32'h12345678;
    step();
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h0800);
    check("wr_mem_wdata", mem_wdata, 32'h12345678);
    check("wr_grant", 32'(last_grant), 32'd1);
    check("wr_early_ack", 32'(b_ack), 32'd0);
    b_req = 0;
    step();
    check("wr_mem_we_off", 32'(mem_we), 32'd0);
    check("wr_b_ack", 32'(b_ack), 32'd1);
    check("wr_b_err", 32'(b_err), 32'd0);
    check("wr_a_ack", 32'(a_ack), 32'd0);
    check("wr_a_rdata_hold", a_rdata, 32'hDEADBEEF);
    step();
    check("wr_ack_drop", 32'(b_ack), 32'd0);

    // Continuous contention: grants alternate A, B, A, B
    a_req = 1; a_we = 0; a_addr = 16'h0020;
    b_req = 1; b_we = 0; b_addr = 16'h0801;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_grant", 32'(last_grant), 32'(k % 2));
      check("rr_busy", 32'(busy), 32'd1);
      mem_rdata = 32'h1000_0000 + 32'(k);
      step();
      check("rr_a_ack", 32'(a_ack), 32'((k % 2) == 0));
      check("rr_b_ack", 32'(b_ack), 32'((k % 2) == 1));
      check("rr_rdata", (k % 2 == 0) ? a_rdata : b_rdata, 32'h1000_0000 + 32'(k));
      step();
      check("rr_idle", 32'(busy), 32'd0);
      check("rr_no_ack", 32'({a_ack, b_ack}), 32'd0);
    end
    a_req = 0; b_req = 0;

    // Errors: B writes ROM, A reads unmapped space
    b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 32'hFFFF_FFFF;
    step();
    check("err_b_ack", 32'(b_ack), 32'd1);
    check("err_b_err", 32'(b_err), 32'd1);
    check("err_b_mem_we", 32'(mem_we), 32'd0);
    check("err_b_mem_addr", 32'(mem_addr), 32'h0801);
    check("err_b_a_ack", 32'(a_ack), 32'd0);
    b_req = 0;
    step();
    check("err_b_ack_drop", 32'({b_ack, b_err}), 32'd0);
    check("err_b_idle", 32'(busy), 32'd0);
    a_req = 1; a_we = 0; a_addr = 16'h0400;
    step();
    check("err_a_ack", 32'(a_ack), 32'd1);
    check("err_a_err", 32'(a_err), 32'd1);
    check("err_a_mem_we", 32'(mem_we), 32'd0);
    check("err_a_mem_addr", 32'(mem_addr), 32'h0801);
    check("err_a_rdata_hold", a_rdata, 32'h1000_0002);
    check("err_b_rdata_hold", b_rdata, 32'h1000_0003);
    a_req = 0;
    step();
    check("err_a_ack_drop", 32'({a_ack, a_err}), 32'd0);

    // Latency-3 read of IO 0x0021, req dropped mid-flight
    a3_req = 1; a3_we = 0; a3_addr = 16'h0021; mem3_rdata = 32'hBAD0BAD0;
    step();
    check("l3_e0_addr", 32'(mem3_addr), 32'h0021);
    check("l3_e0_ack", 32'(a3_ack), 32'd0);
    a3_req = 0;
    step();
    check("l3_e1_addr", 32'(mem3_addr), 32'h0021);
    check("l3_e1_ack", 32'(a3_ack), 32'd0);
    step();
    check("l3_e2_addr", 32'(mem3_addr), 32'h0021);
    check("l3_e2_ack", 32'(a3_ack), 32'd0);
    mem3_rdata = 32'hCAFEF00D;
    step();
    check("l3_e3_ack", 32'(a3_ack), 32'd1);
    check("l3_e3_rdata", a3_rdata, 32'hCAFEF00D);
    check("l3_e3_err", 32'(a3_err), 32'd0);
    mem3_rdata = 32'hBAD0BAD0;
    step();
    check("l3_e4_ack", 32'(a3_ack), 32'd0);
    check("l3_rdata_hold", a3_rdata, 32'hCAFEF00D);

    // Reset in the middle of a write
    a_req = 1; a_we = 1; a_addr = 16'h0900; a_wdata = 32'hA5A5A5A5;
    step();
    check("rw_mem_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0; a_req = 0;
    step();
    check("rw_mem_we_off", 32'(mem_we), 32'd0);
    check("rw_no_ack", 32'({a_ack, b_ack}), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_last_grant", 32'(last_grant), 32'd1);
    check("rw_mem_addr", 32'(mem_addr), 32'h0);
    check("rw_a_rdata", a_rdata, 32'h0);
    check("rw_b_rdata", b_rdata, 32'h0);
    reset_n = 1'b1;
    step();
    check("rw_still_no_ack", 32'({a_ack, b_ack}), 32'd0);
    a_req = 1; a_we = 0; a_addr = 16'h0030;
    b_req = 1; b_we = 0; b_addr = 16'h0030;
    mem_rdata = 32'h0BADCAFE;
    step();
    check("rw_tie_grant", 32'(last_grant), 32'd0);
    a_req = 0; b_req = 0;
    step();
    check("rw_tie_a_ack", 32'(a_ack), 32'd1);
    check("rw_tie_b_ack", 32'(b_ack), 32'd0);
    check("rw_tie_rdata", a_rdata, 32'h0BADCAFE);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
